// File: rtl/ipl_loader_pkg.sv
// Shared types, Avalon lane constants and lane helpers for the IPL loader.
package ipl_loader_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned DATA_W = LANES * LANE_W;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned SUM_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
    ST_VREAD,
    ST_VWAIT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [LANES-1:0]  be;
    logic [DATA_W-1:0] data;
  } word_t;

  // Low-lane enable mask for a word holding n valid bytes (0..4).
  function automatic logic [LANES-1:0] be_from_count(input logic [CNT_W-1:0] n);
    logic [LANES-1:0] be;
    be = '0;
    for (int i = 0; i < LANES; i++) begin
      if (CNT_W'(i) < n) be[i] = 1'b1;
    end
    return be;
  endfunction

  function automatic logic [SUM_W-1:0] lane_sum(input logic [DATA_W-1:0] d,
                                                input logic [LANES-1:0]  be);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) s = s + SUM_W'(d[i*LANE_W +: LANE_W]);
    end
    return s;
  endfunction

endpackage

// File: rtl/ipl_loader_if.sv
// Byte stream sink plus Avalon-MM master bundle of the IPL loader.
interface ipl_loader_if
  import ipl_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 11
);
  logic              in_valid;
  logic [LANE_W-1:0] in_data;
  logic              in_ready;

  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic              avm_read;
  logic [DATA_W-1:0] avm_writedata;
  logic [LANES-1:0]  avm_byteenable;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;

  modport master (
    input  in_valid, in_data, avm_waitrequest, avm_readdata,
    output in_ready, avm_address, avm_write, avm_read, avm_writedata, avm_byteenable
  );

  modport slave (
    output in_valid, in_data, avm_waitrequest, avm_readdata,
    input  in_ready, avm_address, avm_write, avm_read, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/ipl_byte_packer.sv
// Packs bytes little-endian into 32-bit words, tracks tail enables and the byte checksum.
module ipl_byte_packer
  import ipl_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [LANE_W-1:0] byte_i,
  input  logic              take_i,
  output word_t             word_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [SUM_W-1:0]  checksum_o
);

  word_t            word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      cnt_q  <= '0;
      sum_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
    end
  end

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    if (clear_i || take_i) begin
      word_d.data = '0;
      cnt_d       = '0;
    end
    if (clear_i) sum_d = '0;
    if (push_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (cnt_q == CNT_W'(i)) word_d.data[i*LANE_W +: LANE_W] = byte_i;
      end
      cnt_d = cnt_q + CNT_W'(1);
      sum_d = sum_q + SUM_W'(byte_i);
    end
    // Enables follow the fill level so a partial tail word only exposes its valid lanes.
    word_d.be = be_from_count(cnt_d);
  end

  assign word_o     = word_q;
  assign count_o    = cnt_q;
  assign checksum_o = sum_q;

endmodule

// File: rtl/ipl_loader.sv
// Streams a byte image into word memory over Avalon-MM, then reads it back and verifies the sum.
module ipl_loader
  import ipl_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned LEN_W  = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  byte_len,
  ipl_loader_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [SUM_W-1:0]  checksum
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic [LEN_W-1:0]  vleft_q, vleft_d;
  logic [SUM_W-1:0]  vsum_q, vsum_d;
  logic              error_q, error_d;
  logic              busy_q, done_q, wr_q, rd_q, rdy_q;
  logic [LANES-1:0]  rd_be_q;
  logic [CNT_W-1:0]  vcnt_d;

  logic              pk_clear, pk_push, pk_take;
  word_t             pk_word;
  logic [CNT_W-1:0]  pk_count;
  logic [SUM_W-1:0]  pk_sum;

  ipl_byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (pk_clear),
    .push_i     (pk_push),
    .byte_i     (bus.in_data),
    .take_i     (pk_take),
    .word_o     (pk_word),
    .count_o    (pk_count),
    .checksum_o (pk_sum)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      left_q  <= '0;
      vleft_q <= '0;
      vsum_q  <= '0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rdy_q   <= 1'b0;
      rd_be_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      left_q  <= left_d;
      vleft_q <= vleft_d;
      vsum_q  <= vsum_d;
      error_q <= error_d;
      busy_q  <= (state_d == ST_FILL) || (state_d == ST_WRITE) ||
                 (state_d == ST_VREAD) || (state_d == ST_VWAIT);
      done_q  <= (state_d == ST_DONE);
      wr_q    <= (state_d == ST_WRITE);
      rd_q    <= (state_d == ST_VREAD);
      rdy_q   <= (state_d == ST_FILL);
      rd_be_q <= be_from_count(vcnt_d);
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    addr_d   = addr_q;
    len_d    = len_q;
    left_d   = left_q;
    vleft_d  = vleft_q;
    vsum_d   = vsum_q;
    error_d  = error_q;
    pk_clear = 1'b0;
    pk_push  = 1'b0;
    pk_take  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          base_d   = base_addr;
          addr_d   = base_addr;
          len_d    = byte_len;
          left_d   = byte_len;
          vleft_d  = '0;
          vsum_d   = '0;
          error_d  = 1'b0;
          pk_clear = 1'b1;
          state_d  = (byte_len == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (bus.in_valid) begin
          pk_push = 1'b1;
          left_d  = left_q - LEN_W'(1);
          if ((pk_count == CNT_W'(LANES - 1)) || (left_q == LEN_W'(1))) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!bus.avm_waitrequest) begin
          pk_take = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          if (left_q != '0) begin
            state_d = ST_FILL;
          end else begin
            addr_d  = base_q;
            vleft_d = len_q;
            state_d = ST_VREAD;
          end
        end
      end
      ST_VREAD: begin
        if (!bus.avm_waitrequest) state_d = ST_VWAIT;
      end
      ST_VWAIT: begin
        vsum_d = vsum_q + lane_sum(bus.avm_readdata, rd_be_q);
        addr_d = addr_q + ADDR_W'(1);
        if (vleft_q <= LEN_W'(LANES)) begin
          vleft_d = '0;
          error_d = (vsum_d != pk_sum);
          state_d = ST_DONE;
        end else begin
          vleft_d = vleft_q - LEN_W'(LANES);
          state_d = ST_VREAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Read enables for the word about to be verified mirror the write tail rule.
    vcnt_d = (vleft_d >= LEN_W'(LANES)) ? CNT_W'(LANES) : CNT_W'(vleft_d);
  end

  assign bus.in_ready       = rdy_q;
  assign bus.avm_write      = wr_q;
  assign bus.avm_read       = rd_q;
  assign bus.avm_address    = (wr_q || rd_q) ? addr_q : '0;
  assign bus.avm_writedata  = wr_q ? pk_word.data : '0;
  assign bus.avm_byteenable = wr_q ? pk_word.be : (rd_q ? rd_be_q : '0);

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign checksum = pk_sum;

endmodule

// File: tb/tb_ipl_loader.sv
// Directed bench for ipl_loader: byte source and Avalon slave model with stall and corruption knobs.
module tb_ipl_loader;
  import ipl_loader_pkg::*;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned LEN_W  = 13;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  byte_len = '0;
  logic              busy, done, error;
  logic [15:0]       checksum;

  ipl_loader_if #(.ADDR_W(ADDR_W)) bus ();

  ipl_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .byte_len  (byte_len),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Source and slave configuration, shared with the responder loop.
  logic [7:0]        src [0:15];
  int                src_n = 0, src_idx = 0;
  int                stall_cfg = 0, corrupt_rd = -1;
  bit                gap_cfg = 1'b0;

  logic [31:0]       mem [0:2047];
  logic [ADDR_W-1:0] wr_addr [0:7];
  logic [31:0]       wr_data [0:7];
  logic [3:0]        wr_be   [0:7];
  logic [ADDR_W-1:0] rd_addr [0:7];
  logic [3:0]        rd_be   [0:7];
  int                nwr = 0, nrd = 0;

  initial begin
    bit                in_cmd, rd_pend, tog;
    int                stall_left, rd_pend_idx;
    logic [ADDR_W-1:0] rd_pend_addr, snap_a;
    logic [31:0]       snap_d;
    logic [3:0]        snap_be;
    in_cmd = 0; rd_pend = 0; tog = 0; stall_left = 0; rd_pend_idx = 0;
    rd_pend_addr = '0; snap_a = '0; snap_d = '0; snap_be = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata = '0;
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_cmd = 0; rd_pend = 0;
        bus.avm_waitrequest = 1'b0;
        bus.in_valid = 1'b0;
        continue;
      end
      if (rd_pend) begin
        bus.avm_readdata = mem[rd_pend_addr] + ((rd_pend_idx == corrupt_rd) ? 32'd1 : 32'd0);
        rd_pend = 0;
      end
      tog = ~tog;
      if (bus.in_ready && (src_idx < src_n) && !(gap_cfg && tog)) begin
        bus.in_valid = 1'b1;
        bus.in_data  = src[src_idx];
        src_idx++;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.avm_write || bus.avm_read) begin
        if (!in_cmd) begin
          in_cmd = 1; stall_left = stall_cfg;
          snap_a = bus.avm_address; snap_d = bus.avm_writedata; snap_be = bus.avm_byteenable;
          check("cmd_excl", 32'(bus.avm_write && bus.avm_read), 32'd0);
        end else begin
          check("hold_addr", 32'(bus.avm_address), 32'(snap_a));
          check("hold_data", bus.avm_writedata, snap_d);
          check("hold_be", 32'(bus.avm_byteenable), 32'(snap_be));
        end
        if (stall_left > 0) begin
          bus.avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          bus.avm_waitrequest = 1'b0;
          in_cmd = 0;
          if (bus.avm_write) begin
            for (int l = 0; l < 4; l++)
              if (bus.avm_byteenable[l]) mem[bus.avm_address][l*8 +: 8] = bus.avm_writedata[l*8 +: 8];
            if (nwr < 8) begin
              wr_addr[nwr] = bus.avm_address;
              wr_data[nwr] = bus.avm_writedata;
              wr_be[nwr]   = bus.avm_byteenable;
            end
            nwr++;
          end else begin
            if (nrd < 8) begin
              rd_addr[nrd] = bus.avm_address;
              rd_be[nrd]   = bus.avm_byteenable;
            end
            rd_pend = 1; rd_pend_addr = bus.avm_address; rd_pend_idx = nrd;
            nrd++;
          end
        end
      end else begin
        bus.avm_waitrequest = 1'b0;
      end
    end
  end

  task automatic fill_src(input logic [7:0] first, input logic [7:0] step, input int n);
    logic [7:0] b;
    b = first;
    for (int i = 0; i < n; i++) begin
      src[i] = b;
      b = b + step;
    end
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len,
                            input int stall, input bit gap, input int corrupt);
    nwr = 0; nrd = 0; src_idx = 0; src_n = int'(len);
    stall_cfg = stall; gap_cfg = gap; corrupt_rd = corrupt;
    @(negedge clk);
    start = 1'b1; base_addr = base; byte_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done; optionally fires a stray start mid-load that must be ignored.
  task automatic wait_done(input bit poke);
    bit ok;
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin ok = 1; break; end
      if (poke && c == 6) begin start = 1'b1; base_addr = 11'h3FF; byte_len = 13'd1; end
      if (poke && c == 7) start = 1'b0;
      @(negedge clk);
    end
    check("done_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    check("rst_cmd", 32'({bus.avm_write, bus.avm_read, bus.in_ready}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-length load completes next cycle with no bus traffic.
    start_load(11'h055, 13'd0, 0, 1'b0, -1);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check("len0_nwr", 32'(nwr), 32'd0);
    check("len0_nrd", 32'(nrd), 32'd0);
    check("len0_error", 32'(error), 32'd0);

    // Two full words, no stalls.
    fill_src(8'h01, 8'h01, 8);
    start_load(11'h010, 13'd8, 0, 1'b0, -1);
    wait_done(1'b0);
    check("t1_nwr", 32'(nwr), 32'd2);
    check("t1_addr0", 32'(wr_addr[0]), 32'h010);
    check("t1_data0", wr_data[0], 32'h04030201);
    check("t1_be0", 32'(wr_be[0]), 32'hF);
    check("t1_addr1", 32'(wr_addr[1]), 32'h011);
    check("t1_data1", wr_data[1], 32'h08070605);
    check("t1_be1", 32'(wr_be[1]), 32'hF);
    check("t1_nrd", 32'(nrd), 32'd2);
    check("t1_rdaddr0", 32'(rd_addr[0]), 32'h010);
    check("t1_checksum", 32'(checksum), 32'h0024);
    check("t1_done", 32'(done), 32'd1);
    check("t1_error", 32'(error), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);

    // Single-byte tail word with a gappy stream.
    fill_src(8'hAA, 8'h11, 5);
    start_load(11'h020, 13'd5, 0, 1'b1, -1);
    wait_done(1'b0);
    check("t2_nwr", 32'(nwr), 32'd2);
    check("t2_data0", wr_data[0], 32'hDDCCBBAA);
    check("t2_data1", wr_data[1], 32'h000000EE);
    check("t2_be1", 32'(wr_be[1]), 32'h1);
    check("t2_rdbe1", 32'(rd_be[1]), 32'h1);
    check("t2_checksum", 32'(checksum), 32'h03FC);
    check("t2_error", 32'(error), 32'd0);

    // Three-byte tail, 3-cycle stall per command, stray start while busy.
    fill_src(8'h10, 8'h01, 7);
    start_load(11'h040, 13'd7, 3, 1'b1, -1);
    wait_done(1'b1);
    check("t3_nwr", 32'(nwr), 32'd2);
    check("t3_nrd", 32'(nrd), 32'd2);
    check("t3_addr0", 32'(wr_addr[0]), 32'h040);
    check("t3_data0", wr_data[0], 32'h13121110);
    check("t3_addr1", 32'(wr_addr[1]), 32'h041);
    check("t3_data1", wr_data[1], 32'h00161514);
    check("t3_be1", 32'(wr_be[1]), 32'h7);
    check("t3_rdbe1", 32'(rd_be[1]), 32'h7);
    check("t3_checksum", 32'(checksum), 32'h0085);
    check("t3_error", 32'(error), 32'd0);

    // Two-byte tail; slave corrupts the second readback word.
    fill_src(8'h21, 8'h01, 6);
    start_load(11'h060, 13'd6, 0, 1'b0, 1);
    wait_done(1'b0);
    check("t4_data1", wr_data[1], 32'h00002625);
    check("t4_be1", 32'(wr_be[1]), 32'h3);
    check("t4_checksum", 32'(checksum), 32'h00D5);
    check("t4_done", 32'(done), 32'd1);
    check("t4_error", 32'(error), 32'd1);

    // Reset asserted while a write is stalled, then a wrapping reload.
    fill_src(8'h41, 8'h01, 8);
    start_load(11'h100, 13'd8, 3, 1'b0, -1);
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.avm_write) begin seen = 1; break; end
      @(negedge clk);
    end
    check("t5_write_seen", 32'(seen), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_write", 32'(bus.avm_write), 32'd0);
    check("t5_rst_read", 32'(bus.avm_read), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_ready", 32'(bus.in_ready), 32'd0);
    check("t5_rst_checksum", 32'(checksum), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    fill_src(8'h31, 8'h01, 8);
    start_load(11'h7FF, 13'd8, 1, 1'b0, -1);
    wait_done(1'b0);
    check("t5_nwr", 32'(nwr), 32'd2);
    check("t5_addr0", 32'(wr_addr[0]), 32'h7FF);
    check("t5_data0", wr_data[0], 32'h34333231);
    check("t5_addr1", 32'(wr_addr[1]), 32'h000);
    check("t5_data1", wr_data[1], 32'h38373635);
    check("t5_rdaddr1", 32'(rd_addr[1]), 32'h000);
    check("t5_checksum", 32'(checksum), 32'h01A4);
    check("t5_error", 32'(error), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
